// File: rtl/fwd_stall_ctrl.sv
// Turns the distance-1 hazard report into registered E-stage forwarding selects,
// load-use stall/bubble controls, a sticky protocol-error flag and a stall counter.
module fwd_stall_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             conf,
   input  logic [3:0]       outtype,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             proto_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, STALL, RESUME} state_t;
   typedef enum logic [1:0] {PEND_NONE, PEND_A, PEND_B} pend_t;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);
   localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);

   state_t     state, state_nx;
   pend_t      pend, pend_nx;
   logic [2:0] count, count_nx;
   logic [1:0] fwd_a_nx, fwd_b_nx;
   logic       err_nx;
   logic       stall;
   logic       type_ok, hz_load, hz_a, hz_b;

   always_comb begin
      type_ok = (outtype != 4'd0) && (outtype <= 4'd4);
      hz_a    = conf && (outtype == 4'd1);
      hz_b    = conf && (outtype == 4'd2);
      hz_load = conf && ((outtype == 4'd3) || (outtype == 4'd4));

      state_nx = state;
      pend_nx  = pend;
      count_nx = count;
      fwd_a_nx = FWD_REG;
      fwd_b_nx = FWD_REG;
      err_nx   = proto_err;
      stall    = 1'b0;

      case (state)
         STALL: begin
            stall    = 1'b1;
            count_nx = count - 3'd1;
            if (count_nx == 3'd0) state_nx = RESUME;
         end
         default: begin
            if (conf && !type_ok) err_nx = 1'b1;
            // A pending load result always wins on its own operand; an R-type hit on the other operand still forwards.
            fwd_a_nx = (pend == PEND_A) ? FWD_MEMWB : (hz_a ? FWD_EXMEM : FWD_REG);
            fwd_b_nx = (pend == PEND_B) ? FWD_MEMWB : (hz_b ? FWD_EXMEM : FWD_REG);
            pend_nx  = PEND_NONE;
            state_nx = RUN;
            if (hz_load) begin
               stall    = 1'b1;
               pend_nx  = (outtype == 4'd3) ? PEND_A : PEND_B;
               count_nx = STALL_LOAD;
               state_nx = MULTI_STALL ? STALL : RESUME;
            end
         end
      endcase
   end

   // Gate with rst so the stall controls drop in the same cycle reset is raised.
   always_comb begin
      stall_pc    = stall && !rst;
      stall_ifid  = stall && !rst;
      bubble_idex = stall && !rst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         pend      <= PEND_NONE;
         count     <= 3'd0;
         fwd_a     <= FWD_REG;
         fwd_b     <= FWD_REG;
         proto_err <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nx;
         pend      <= pend_nx;
         count     <= count_nx;
         fwd_a     <= fwd_a_nx;
         fwd_b     <= fwd_b_nx;
         proto_err <= err_nx;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Drives three parameterisations of fwd_stall_ctrl with shared stimulus and checks each
// every cycle against a cycle-count/queue-free behavioural model plus directed literal checks.
module tb_fwd_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       conf = 1'b0;
   logic [3:0] outtype = 4'd0;

   logic       sp [3];
   logic       si [3];
   logic       bi [3];
   logic       pe [3];
   logic [1:0] fa [3];
   logic [1:0] fb [3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state per instance: remaining stall cycles, pending operand (0 none, 1 A, 2 B).
   int m_stall_cycles [3] = '{1, 3, 1};
   int m_max          [3] = '{65535, 65535, 3};
   int m_left [3];
   int m_pend [3];
   int m_fa   [3];
   int m_fb   [3];
   int m_cnt  [3];
   int m_err  [3];

   always #5 clk = ~clk;

   fwd_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_d1 (
      .clk(clk), .rst(rst), .conf(conf), .outtype(outtype),
      .stall_pc(sp[0]), .stall_ifid(si[0]), .bubble_idex(bi[0]),
      .fwd_a(fa[0]), .fwd_b(fb[0]), .proto_err(pe[0]), .stall_cnt(cnt0));

   fwd_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_d3 (
      .clk(clk), .rst(rst), .conf(conf), .outtype(outtype),
      .stall_pc(sp[1]), .stall_ifid(si[1]), .bubble_idex(bi[1]),
      .fwd_a(fa[1]), .fwd_b(fb[1]), .proto_err(pe[1]), .stall_cnt(cnt1));

   fwd_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u_dc (
      .clk(clk), .rst(rst), .conf(conf), .outtype(outtype),
      .stall_pc(sp[2]), .stall_ifid(si[2]), .bubble_idex(bi[2]),
      .fwd_a(fa[2]), .fwd_b(fb[2]), .proto_err(pe[2]), .stall_cnt(cnt2));

   function automatic int dut_cnt(input int i);
      if (i == 0) return int'(cnt0);
      if (i == 1) return int'(cnt1);
      return int'(cnt2);
   endfunction

   function automatic int exp_stall(input int i);
      if (rst) return 0;
      if (m_left[i] > 0) return 1;
      return (conf && (outtype == 4'd3 || outtype == 4'd4)) ? 1 : 0;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit c, input logic [3:0] t);
      @(posedge clk);
      #1;
      rst = r;
      conf = c;
      outtype = t;
      @(negedge clk);
   endtask

   task automatic modelStep(input int i);
      int  st;
      bit  hz_ok, load;
      st = exp_stall(i);
      if (st != 0 && m_cnt[i] < m_max[i]) m_cnt[i]++;
      if (m_left[i] > 0) begin
         m_left[i]--;
         m_fa[i] = 0;
         m_fb[i] = 0;
      end else begin
         hz_ok = conf && outtype >= 4'd1 && outtype <= 4'd4;
         load  = hz_ok && outtype >= 4'd3;
         if (conf && !hz_ok) m_err[i] = 1;
         m_fa[i] = (m_pend[i] == 1) ? 2 : ((hz_ok && outtype == 4'd1) ? 1 : 0);
         m_fb[i] = (m_pend[i] == 2) ? 2 : ((hz_ok && outtype == 4'd2) ? 1 : 0);
         m_pend[i] = load ? int'(outtype) - 2 : 0;
         if (load) m_left[i] = m_stall_cycles[i] - 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_left[i] = 0; m_pend[i] = 0; m_fa[i] = 0; m_fb[i] = 0;
            m_cnt[i] = 0;  m_err[i] = 0;
         end else begin
            modelStep(i);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("stall_pc[%0d]", i), int'(sp[i]), exp_stall(i));
         checkOutput($sformatf("stall_ifid[%0d]", i), int'(si[i]), exp_stall(i));
         checkOutput($sformatf("bubble_idex[%0d]", i), int'(bi[i]), exp_stall(i));
         checkOutput($sformatf("fwd_a[%0d]", i), int'(fa[i]), m_fa[i]);
         checkOutput($sformatf("fwd_b[%0d]", i), int'(fb[i]), m_fb[i]);
         checkOutput($sformatf("proto_err[%0d]", i), int'(pe[i]), m_err[i]);
         checkOutput($sformatf("stall_cnt[%0d]", i), dut_cnt(i), m_cnt[i]);
      end
   end

   task automatic resetDut();
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("reset stall_pc", int'(sp[0]), 0);
      checkOutput("reset stall_cnt", int'(cnt0), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(negedge clk);
      resetDut();
      checkOutput("post-reset fwd_a", int'(fa[0]), 0);

      applyStimulus(1'b0, 1'b1, 4'd1);
      checkOutput("rtype A no stall", int'(sp[0]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("rtype A fwd_a", int'(fa[0]), 1);
      checkOutput("rtype A fwd_b", int'(fb[0]), 0);
      applyStimulus(1'b0, 1'b1, 4'd2);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("rtype B fwd_b", int'(fb[0]), 1);
      checkOutput("rtype B fwd_a", int'(fa[0]), 0);

      applyStimulus(1'b0, 1'b1, 4'd3);
      checkOutput("load1 stall_pc", int'(sp[0]), 1);
      checkOutput("load1 bubble", int'(bi[0]), 1);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("load1 resume stall", int'(sp[0]), 0);
      checkOutput("load1 stall_cnt", int'(cnt0), 1);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("load1 fwd_a", int'(fa[0]), 2);
      checkOutput("load1 fwd_b", int'(fb[0]), 0);

      resetDut();
      applyStimulus(1'b0, 1'b1, 4'd4);
      checkOutput("load3 stall c0", int'(sp[1]), 1);
      applyStimulus(1'b0, 1'b1, 4'd1);
      checkOutput("load3 stall c1", int'(sp[1]), 1);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("load3 stall c2", int'(bi[1]), 1);
      applyStimulus(1'b0, 1'b1, 4'd2);
      checkOutput("load3 resume stall", int'(sp[1]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("load3 fwd_b", int'(fb[1]), 2);
      checkOutput("load3 fwd_a", int'(fa[1]), 0);
      checkOutput("load3 stall_cnt", int'(cnt1), 3);

      resetDut();
      applyStimulus(1'b0, 1'b1, 4'd3);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("midstall stall", int'(sp[1]), 1);
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("midstall rst stall_pc", int'(sp[1]), 0);
      checkOutput("midstall rst bubble", int'(bi[1]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("midstall after stall", int'(sp[1]), 0);
      checkOutput("midstall after fwd_a", int'(fa[1]), 0);

      resetDut();
      applyStimulus(1'b0, 1'b1, 4'd3);
      applyStimulus(1'b0, 1'b1, 4'd4);
      checkOutput("b2b second stall", int'(sp[0]), 1);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("b2b fwd_a", int'(fa[0]), 2);
      checkOutput("b2b fwd_b first", int'(fb[0]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("b2b fwd_b", int'(fb[0]), 2);
      checkOutput("b2b fwd_a second", int'(fa[0]), 0);
      checkOutput("b2b stall_cnt", int'(cnt0), 2);

      resetDut();
      applyStimulus(1'b0, 1'b1, 4'd7);
      checkOutput("err no stall", int'(sp[0]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("err set", int'(pe[0]), 1);
      checkOutput("err fwd_a", int'(fa[0]), 0);
      checkOutput("err fwd_b", int'(fb[0]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput("err sticky", int'(pe[0]), 1);

      resetDut();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b1, 4'd3);
         applyStimulus(1'b0, 1'b0, 4'd0);
      end
      checkOutput("sat stall_cnt", int'(cnt2), 3);
      checkOutput("nosat stall_cnt", int'(cnt0), 5);

      resetDut();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
         end else if ($urandom_range(0, 39) == 0) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(5, 15)));
         end else begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
         end
      end
      applyStimulus(1'b0, 1'b0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
